// File: rtl/apb_cmd_pkg.sv
// Shared types and default sizing for the APB command queue and its FIFO.
package apb_cmd_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPT,
    ST_RESP
  } state_e;

  // Struct field widths follow the package defaults; the top is built at these widths.
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; the head entry is readable
// combinationally so the sequencer can load it in the same cycle it pops.
module apb_cmd_fifo
  import apb_cmd_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  cmd_t                   din,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  cmd_t            mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [LW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_cmd_queue.sv
// Buffers host read/write commands and issues them one at a time to the APB
// master's user interface, returning one response per command (or per timeout).
module apb_cmd_queue
  import apb_cmd_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   Transfer,
  output logic                   Wr_Rd,
  output logic [ADDR_W-1:0]      Address,
  output logic [DATA_W-1:0]      write_data,
  input  logic [DATA_W-1:0]      read_data,
  input  logic                   xfer_done,
  input  logic                   xfer_err,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e              state_q;
  logic                transfer_q;
  logic                wr_rd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic                timeout_q;
  logic                rsp_valid_q;
  rsp_t                rsp_q;

  cmd_t                fifo_din;
  cmd_t                fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;

  always_comb begin
    fifo_din       = '0;
    fifo_din.write = cmd_write;
    fifo_din.addr  = cmd_addr;
    fifo_din.wdata = cmd_wdata;
  end

  // A pop in the same cycle never frees a slot while full: ready is purely !full.
  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & ~fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;

  apb_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      transfer_q  <= 1'b0;
      wr_rd_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      transfer_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            wr_rd_q    <= fifo_head.write;
            addr_q     <= fifo_head.addr;
            wdata_q    <= fifo_head.wdata;
            transfer_q <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q     <= '0;
          err_q     <= 1'b0;
          timeout_q <= 1'b0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (xfer_done) begin
            err_q   <= xfer_err;
            state_q <= ST_CAPT;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= ST_CAPT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_CAPT: begin
          // Master registers PRDATA on completion, so read_data is valid here.
          rsp_q.write <= wr_rd_q;
          rsp_q.err   <= err_q;
          rsp_q.rdata <= (!wr_rd_q && !timeout_q) ? read_data : '0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Transfer   = transfer_q;
  assign Wr_Rd      = wr_rd_q;
  assign Address    = addr_q;
  assign write_data = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_q.write;
  assign rsp_rdata  = rsp_q.rdata;
  assign rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Directed bench for apb_cmd_queue: a scripted slave drives xfer_done/read_data,
// a scoreboard queue holds expected responses checked by a separate monitor.
module tb_apb_cmd_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              PCLK;
  logic              PRESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              Transfer;
  logic              Wr_Rd;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              xfer_done;
  logic              xfer_err;
  logic [2:0]        level;

  apb_cmd_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Transfer(Transfer), .Wr_Rd(Wr_Rd), .Address(Address), .write_data(write_data),
    .read_data(read_data), .xfer_done(xfer_done), .xfer_err(xfer_err),
    .level(level)
  );

  typedef struct {
    bit                w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                ws;
    bit                serr;
    bit                hang;
    logic [DATA_W-1:0] rdata;
  } slv_t;

  typedef struct {
    bit                w;
    logic [DATA_W-1:0] rdata;
    bit                err;
  } exp_t;

  slv_t slave_q[$];
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tr_cyc = 0;
  int rise_cyc = 0;
  int n_tr = 0;
  int n_rsp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Transfer monitor: single-cycle pulses, never while a response is pending.
  initial begin : tr_mon
    bit prev_tr;
    prev_tr = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        prev_tr = 1'b0;
      end else begin
        if (Transfer) begin
          check("xfer_pulse_width", 64'(prev_tr), 64'd0);
          check("xfer_while_rsp", 64'(rsp_valid), 64'd0);
          if (!prev_tr) begin
            n_tr++;
            tr_cyc = cyc;
          end
        end
        prev_tr = Transfer;
      end
    end
  end

  // Scripted slave: completes each transfer after the given wait states.
  initial begin : slave
    slv_t b;
    forever begin
      @(negedge PCLK);
      if (!PRESET && Transfer) begin
        checks++;
        if (slave_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transfer: addr=0x%0h with no queued command", Address);
        end else begin
          b = slave_q.pop_front();
          check("issue_wr_rd", 64'(Wr_Rd), 64'(b.w));
          check("issue_addr", 64'(Address), 64'(b.a));
          if (b.w) check("issue_wdata", 64'(write_data), 64'(b.d));
          if (!b.hang) begin
            @(posedge PCLK);
            repeat (1 + b.ws) @(posedge PCLK);
            #1;
            xfer_done = 1'b1;
            xfer_err  = b.serr;
            @(posedge PCLK);
            #1;
            xfer_done = 1'b0;
            xfer_err  = 1'b0;
            read_data = b.rdata;
          end
        end
      end
    end
  end

  // Response monitor: scoreboard pop on handshake, stability while stalled.
  initial begin : rsp_mon
    bit                prev_rv;
    bit                prev_rr;
    bit                h_w;
    bit                h_e;
    logic [DATA_W-1:0] h_d;
    exp_t              e;
    prev_rv = 1'b0;
    prev_rr = 1'b0;
    h_w = 1'b0;
    h_e = 1'b0;
    h_d = '0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        prev_rv = 1'b0;
        prev_rr = 1'b0;
      end else begin
        if (rsp_valid && !prev_rv) rise_cyc = cyc;
        if (rsp_valid && prev_rv && !prev_rr) begin
          check("stall_rsp_write", 64'(rsp_write), 64'(h_w));
          check("stall_rsp_rdata", 64'(rsp_rdata), 64'(h_d));
          check("stall_rsp_err", 64'(rsp_err), 64'(h_e));
        end
        if (rsp_valid && rsp_ready) begin
          n_rsp++;
          $display("rsp #%0d write=%0b rdata=0x%08h err=%0b", n_rsp, rsp_write, rsp_rdata, rsp_err);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got a response with none expected");
          end else begin
            e = exp_q.pop_front();
            check("rsp_write", 64'(rsp_write), 64'(e.w));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
          end
        end
        h_w = rsp_write;
        h_d = rsp_rdata;
        h_e = rsp_err;
        prev_rv = rsp_valid;
        prev_rr = rsp_ready;
      end
    end
  end

  function automatic slv_t mk_slv(bit w, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                                  int ws, bit serr, bit hang, logic [DATA_W-1:0] rd);
    slv_t s;
    s.w = w; s.a = a; s.d = d; s.ws = ws; s.serr = serr; s.hang = hang; s.rdata = rd;
    return s;
  endfunction

  function automatic exp_t mk_exp(bit w, logic [DATA_W-1:0] rd, bit err);
    exp_t x;
    x.w = w; x.rdata = rd; x.err = err;
    return x;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push_cmd(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int ws, input bit serr, input bit hang,
                          input logic [DATA_W-1:0] srd, input logic [DATA_W-1:0] erd,
                          input bit eerr, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge PCLK);
      if (cmd_ready) begin
        @(posedge PCLK);
        #1;
        got = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (got) begin
      acc = cyc;
      slave_q.push_back(mk_slv(w, a, d, ws, serr, hang, srd));
      exp_q.push_back(mk_exp(w, erd, eerr));
    end else begin
      check("push_accept_timeout", 64'd0, 64'd1);
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge PCLK);
      if (exp_q.size() == 0 && !rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("wait_idle_timeout", 64'd0, 64'd1);
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_rsp_valid();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("wait_rsp_timeout", 64'd0, 64'd1);
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_Transfer"},   64'(Transfer),   64'd0);
    check({tag, "_Wr_Rd"},      64'(Wr_Rd),      64'd0);
    check({tag, "_Address"},    64'(Address),    64'd0);
    check({tag, "_write_data"}, 64'(write_data), 64'd0);
    check({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    check({tag, "_rsp_write"},  64'(rsp_write),  64'd0);
    check({tag, "_rsp_rdata"},  64'(rsp_rdata),  64'd0);
    check({tag, "_rsp_err"},    64'(rsp_err),    64'd0);
    check({tag, "_level"},      64'(level),      64'd0);
    check({tag, "_cmd_ready"},  64'(cmd_ready),  64'd1);
  endtask

  initial begin : stim
    int acc;
    int p;
    int snap;
    bit got;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    xfer_done = 1'b0;
    xfer_err  = 1'b0;
    read_data = '0;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_reset_vals("reset");
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;

    // Write 0xA5 to address 3, then read it back.
    push_cmd(1'b1, 5'd3, 32'h0000_00A5, 0, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 1'b0, acc);
    wait_idle();
    check("wr_accept_to_rsp", 64'(rise_cyc - acc), 64'd5);
    check("wr_xfer_to_rsp", 64'(rise_cyc - tr_cyc), 64'd4);
    push_cmd(1'b0, 5'd3, 32'h0, 0, 1'b0, 1'b0, 32'h0000_00A5, 32'h0000_00A5, 1'b0, acc);
    wait_idle();
    check("rd_accept_to_rsp", 64'(rise_cyc - acc), 64'd5);

    // Three slave wait states add three cycles.
    push_cmd(1'b0, 5'd3, 32'h0, 3, 1'b0, 1'b0, 32'h0000_00A5, 32'h0000_00A5, 1'b0, acc);
    wait_idle();
    check("ws3_accept_to_rsp", 64'(rise_cyc - acc), 64'd8);

    // Slave error on a read, then a normal write.
    push_cmd(1'b0, 5'd7, 32'h0, 0, 1'b1, 1'b0, 32'hBAD0_0001, 32'hBAD0_0001, 1'b1, acc);
    wait_idle();
    push_cmd(1'b1, 5'd7, 32'h0000_0077, 0, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 1'b0, acc);
    wait_idle();
    check("after_err_latency", 64'(rise_cyc - acc), 64'd5);

    // Timeout: slave never completes.
    push_cmd(1'b0, 5'd9, 32'h0, 0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, acc);
    wait_idle();
    check("timeout_xfer_to_rsp", 64'(rise_cyc - tr_cyc), 64'(TIMEOUT + 2));

    // Backpressure: hold the first response for 10 cycles.
    rsp_ready = 1'b0;
    push_cmd(1'b1, 5'd2, 32'h0000_0022, 0, 1'b0, 1'b0, 32'h0000_9999, 32'h0, 1'b0, acc);
    push_cmd(1'b0, 5'd4, 32'h0, 0, 1'b0, 1'b0, 32'h0000_0055, 32'h0000_0055, 1'b0, acc);
    wait_rsp_valid();
    snap = n_tr;
    repeat (10) @(posedge PCLK);
    #1;
    check("bp_no_second_issue", 64'(n_tr), 64'(snap));
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1;
    rsp_ready = 1'b0;
    @(negedge PCLK);
    check("bp_idle_after_hs", 64'(Transfer), 64'd0);
    @(negedge PCLK);
    check("bp_issue_1_after_hs", 64'(Transfer), 64'd1);
    wait_rsp_valid();
    repeat (3) @(posedge PCLK);
    #1;
    rsp_ready = 1'b1;
    wait_idle();

    // Fill: one response held, four queued, fifth waits for a pop.
    rsp_ready = 1'b0;
    push_cmd(1'b0, 5'd11, 32'h0, 0, 1'b0, 1'b0, 32'h0000_00B0, 32'h0000_00B0, 1'b0, acc);
    wait_rsp_valid();
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b0, 5'(12 + i), 32'h0, 0, 1'b0, 1'b0, 32'(32'hC1 + i), 32'(32'hC1 + i), 1'b0, acc);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'd16;
    cmd_wdata = '0;
    repeat (3) begin
      @(negedge PCLK);
      check("full_cmd_ready", 64'(cmd_ready), 64'd0);
      check("full_level", 64'(level), 64'd4);
    end
    @(posedge PCLK);
    #1;
    rsp_ready = 1'b1;
    p = cyc;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge PCLK);
      if (cmd_ready) begin
        @(posedge PCLK);
        #1;
        got = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    check("fifth_accepted", 64'(got), 64'd1);
    if (got) begin
      slave_q.push_back(mk_slv(1'b0, 5'd16, 32'h0, 0, 1'b0, 1'b0, 32'h0000_00C5));
      exp_q.push_back(mk_exp(1'b0, 32'h0000_00C5, 1'b0));
      check("fifth_accept_delay", 64'(cyc - p), 64'd3);
      @(negedge PCLK);
      check("fifth_level", 64'(level), 64'd4);
    end
    wait_idle();

    // Reset in WAIT with three commands still queued.
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b0, 5'(20 + i), 32'h0, 0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, acc);
    end
    @(negedge PCLK);
    check("pre_rst_level", 64'(level), 64'd3);
    PRESET = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(posedge PCLK);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    exp_q.delete();
    slave_q.delete();
    snap = n_tr;
    repeat (40) @(posedge PCLK);
    #1;
    check("post_rst_no_issue", 64'(n_tr), 64'(snap));
    check("post_rst_level", 64'(level), 64'd0);
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
